pipe_chain: RTL and testbench
=============================

Name: pipe_chain

Overview:
- Parametrised elastic N-stage pipeline fabric: per-stage valid/payload registers, stall and flush control, valid/ready handshake at both ends.
- Generalises the fixed IF-ID/ID-EX/EX-MM/MM-WB pipeline registers and their central stall/flush controller into one block.
- Combinational stage logic lives outside. It reads each stage's registered payload and returns the transformed payload to be captured by the next stage.
- Adds full-throughput bubble collapsing, downstream backpressure and retire/bubble performance counters.

Parameters:
- STAGES, 5, number of register stages (≥2); stage 0 youngest, stage STAGES-1 oldest.
- WIDTH, 64, payload bits per stage.
- CNT_W, 32, performance counter width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  producer offers in_data
- in_ready  output  1  stage 0 accepts this cycle
- in_data  input  WIDTH  payload captured into stage 0
- stage_valid_o  output  STAGES  registered valid bit per stage
- stage_data_o  output  STAGES*WIDTH  registered payload per stage; slice i = [i*WIDTH +: WIDTH]
- stage_next_i  input  STAGES*WIDTH  transformed payload of stage i; slice i is captured by stage i+1; last slice drives out_data
- stall_req  input  STAGES  stage i must hold its item this cycle
- flush_req  input  STAGES  kill stage k and every younger stage (0..k)
- out_valid  output  1  oldest stage presents a result
- out_ready  input  1  consumer accepts
- out_data  output  WIDTH  = stage_next_i last slice
- retire_cnt  output  CNT_W  number of completed out handshakes
- bubble_cnt  output  CNT_W  cycles with out_ready=1 and out_valid=0

Behaviour:
- Reset, asynchronous and immediate, including mid-stream:
  - valid_q, data_q, retire_cnt and bubble_cnt go to 0.
  - out_valid falls to 0 without waiting for a clock edge.
  - in_ready is 1 after reset, provided no stall or flush is asserted.
- Kill mask: kill[i] = OR of flush_req[k] for all k ≥ i. Multiple flushes form a union, so the highest index dominates.
- Move:
  - move[i] = valid_q[i] & ~stall_req[i] & ~kill[i] & downstream_ok[i].
  - downstream_ok[last] = out_ready. Otherwise downstream_ok[i] = accept[i+1].
  - accept[i] = ~kill[i] & (~valid_q[i] | move[i]).
  - The accept/move chain is evaluated combinationally from the tail. A full pipeline advances one item per cycle with no bubble.
- Outputs:
  - out_valid = valid_q[last] & ~stall_req[last] & ~kill[last].
  - in_ready = accept[0].
  - The in handshake fires when in_valid & in_ready.
- Per-stage update at each edge:
  - kill[i]: valid_q[i] ← 0.
  - else accept[i]: valid_q[i] ← incoming valid (in handshake for i=0, move[i-1] otherwise); data_q[i] ← in_data or the stage_next_i slice i-1, captured only when incoming valid = 1.
  - else: hold.
- Stall semantics:
  - A stalled valid stage holds its item, and every older-fed stage upstream of it holds or fills.
  - The stage directly after it receives a bubble.
  - A stall on an invalid stage does not block it; a bubble passes through.
- Flush vs stall: flush wins. A killed item never reaches the next stage and never produces out_valid.
- Latency: an item accepted at edge t is visible on out_valid after edge t+STAGES-1 with no stalls.
- Ordering: items are never reordered, duplicated or lost except by flush.
- Counters:
  - retire_cnt increments on each out handshake.
  - bubble_cnt increments on out_ready & ~out_valid.
  - Both wrap modulo 2^CNT_W.
- Payload of invalid stages is don't-care to consumers. The bench compares only valid slots.

Decomposition:
- Shared package includes::, holding:
  - the PIPE_STAGES_DEFAULT and PIPE_WIDTH_DEFAULT constants;
  - a pipe_ctl_t packed struct {stall, flush} per stage, for controllers that build stall_req/flush_req.
- Sub-module pipe_chain_stage: one slot holding valid_q and data_q, with inputs incoming valid/data, accept and kill. Generated STAGES times.
- Move/accept ripple and counters stay in pipe_chain.

Test Plan:
1. Reset, then stream 0x01..0x0A with out_ready=1 (STAGES=5, WIDTH=8, identity transform) -> first out_valid 4 cycles after first accept; 10 consecutive outputs in order; retire_cnt=10.
2. out_ready=0 while streaming -> in_ready drops after 5 accepts. Release out_ready -> 0x01..0x05 emerge in order, then the rest, no duplicates.
3. Full pipeline, stall_req[2]=1 for one cycle -> stages 0-2 hold, stage 3 becomes invalid, out stream shows exactly one gap, bubble_cnt=1.
4. Items A..E in stages 0..4, flush_req[1] one cycle -> A,B killed, in_ready=0 that cycle, C,D,E retire; next input follows E.
5. flush_req[4] with stall_req[2] in the same cycle -> all stage_valid_o=0 next cycle, out_valid=0 that cycle, retire_cnt unchanged.
6. CNT_W=4, 17 retirements -> retire_cnt=1. Assert rst mid-stream -> out_valid and counters 0 before the next clk edge.

Source files
------------

// File: rtl/pipe_chain_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_chain_pkg : shared constants and control types for pipe_chain       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package pipe_chain_pkg;

  localparam int PIPE_STAGES_DEFAULT = 5;
  localparam int PIPE_WIDTH_DEFAULT  = 64;

  // Per-stage control pair for controllers that assemble stall_req/flush_req.
  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_ctl_t;

endpackage
`default_nettype wire

// File: rtl/pipe_chain_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_chain_stage : one valid/payload slot of the elastic pipeline        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pipe_chain_stage
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             accept,
  input  logic             kill,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Kill beats accept; payload only moves when a real item arrives.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (kill) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_chain : parametrised elastic N-stage pipeline with stall/flush      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter int STAGES = PIPE_STAGES_DEFAULT,
  parameter int WIDTH  = PIPE_WIDTH_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  output logic [STAGES-1:0]       stage_valid_o,
  output logic [STAGES*WIDTH-1:0] stage_data_o,
  input  logic [STAGES*WIDTH-1:0] stage_next_i,
  input  logic [STAGES-1:0]       stall_req,
  input  logic [STAGES-1:0]       flush_req,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CNT_W-1:0]        retire_cnt,
  output logic [CNT_W-1:0]        bubble_cnt
);

  localparam int               LAST    = STAGES - 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] move;
  logic [STAGES-1:0] inc_valid;
  logic [STAGES:0]   kill_ext;
  logic [STAGES:0]   acc_ext;
  logic [CNT_W-1:0]  retire_cnt_q;
  logic [CNT_W-1:0]  retire_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_d;

  // Extra top bit of each chain stands for the consumer side of the last stage.
  always_comb begin
    kill_ext         = '0;
    acc_ext          = '0;
    move             = '0;
    acc_ext[STAGES]  = out_ready;
    for (int i = LAST; i >= 0; i--) begin
      kill_ext[i] = kill_ext[i+1] | flush_req[i];
      move[i]     = valid_q[i] & ~stall_req[i] & ~kill_ext[i] & acc_ext[i+1];
      acc_ext[i]  = ~kill_ext[i] & (~valid_q[i] | move[i]);
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [WIDTH-1:0] inc_data;

    if (i == 0) begin : g_head
      assign inc_valid[i] = in_valid & acc_ext[0];
      assign inc_data     = in_data;
    end else begin : g_body
      assign inc_valid[i] = move[i-1];
      assign inc_data     = stage_next_i[(i-1)*WIDTH +: WIDTH];
    end

    pipe_chain_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (inc_valid[i]),
      .in_data  (inc_data),
      .accept   (acc_ext[i]),
      .kill     (kill_ext[i]),
      .valid_o  (valid_q[i]),
      .data_o   (stage_data_o[i*WIDTH +: WIDTH])
    );
  end

  assign stage_valid_o = valid_q;
  assign in_ready      = acc_ext[0];
  assign out_valid     = valid_q[LAST] & ~stall_req[LAST] & ~kill_ext[LAST];
  assign out_data      = stage_next_i[LAST*WIDTH +: WIDTH];

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && out_ready) begin
      retire_cnt_d = retire_cnt_q + CNT_ONE;
    end
    if (out_ready && !out_valid) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_chain : directed and randomized checks of pipe_chain             |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pipe_chain;

  localparam int ST = 5;
  localparam int W  = 8;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_data = '0;
  logic [ST-1:0]   stage_valid_o;
  logic [ST*W-1:0] stage_data_o;
  logic [ST*W-1:0] stage_next_i;
  logic [ST-1:0]   stall_req = '0;
  logic [ST-1:0]   flush_req = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_data;
  logic [CW-1:0]   retire_cnt;
  logic [CW-1:0]   bubble_cnt;

  bit xf_en = 1'b0;

  pipe_chain #(.STAGES(ST), .WIDTH(W), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .stage_valid_o (stage_valid_o),
    .stage_data_o  (stage_data_o),
    .stage_next_i  (stage_next_i),
    .stall_req     (stall_req),
    .flush_req     (flush_req),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .retire_cnt    (retire_cnt),
    .bubble_cnt    (bubble_cnt)
  );

  always #5 clk = ~clk;

  // External stage logic: identity, or a per-stage offset so slice mix-ups show.
  always_comb begin
    stage_next_i = '0;
    for (int i = 0; i < ST; i++)
      stage_next_i[i*W +: W] = stage_data_o[i*W +: W] + (xf_en ? W'(i*37+1) : W'(0));
  end

  function automatic logic [W-1:0] xf(logic [W-1:0] d, int i);
    return xf_en ? d + W'(i*37+1) : d;
  endfunction

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: slots of optional items -------------
  bit            mval[ST];
  logic [W-1:0]  mdat[ST];
  logic [CW-1:0] m_ret, m_bub;
  bit            takes[ST], leaves[ST];
  bit            e_in_ready, e_out_valid;
  int            kb;

  // An item leaves its slot when not stalled/killed and the slot ahead has room.
  function automatic void model_eval();
    bit room;
    kb = -1;
    for (int k = 0; k < ST; k++) if (flush_req[k]) kb = k;
    room = out_ready;
    for (int i = ST-1; i >= 0; i--) begin
      if (i <= kb)                          begin takes[i] = 0; leaves[i] = 0; room = 0; end
      else if (!mval[i])                    begin takes[i] = 1; leaves[i] = 0; room = 1; end
      else if (stall_req[i] || !room)       begin takes[i] = 0; leaves[i] = 0; room = 0; end
      else                                  begin takes[i] = 1; leaves[i] = 1; room = 1; end
    end
    e_in_ready  = takes[0];
    e_out_valid = mval[ST-1] && !stall_req[ST-1] && (ST-1 > kb);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ST; i++) mval[i] <= 1'b0;
      m_ret <= '0;
      m_bub <= '0;
    end else begin : upd
      bit           nv[ST];
      logic [W-1:0] nd[ST];
      bit           inc;
      model_eval();
      for (int i = 0; i < ST; i++) begin
        nv[i] = mval[i];
        nd[i] = mdat[i];
        if (i <= kb) nv[i] = 1'b0;
        else if (takes[i]) begin
          if (i == 0) inc = in_valid;
          else        inc = leaves[i-1];
          nv[i] = inc;
          if (inc) nd[i] = (i == 0) ? in_data : xf(mdat[i-1], i-1);
        end
      end
      for (int i = 0; i < ST; i++) begin
        mval[i] <= nv[i];
        mdat[i] <= nd[i];
      end
      if (leaves[ST-1])                m_ret <= m_ret + 1'b1;
      if (out_ready && !e_out_valid)   m_bub <= m_bub + 1'b1;
    end
  end

  // ---------------- compare process ---------------------------------------
  int           cyc = 0;
  int           first_acc = -1, first_out = -1;
  logic [W-1:0] got[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin : cmp
      logic [ST-1:0] ev;
      model_eval();
      for (int i = 0; i < ST; i++) ev[i] = mval[i];
      chk("stage_valid", 32'(stage_valid_o), 32'(ev));
      for (int i = 0; i < ST; i++)
        if (mval[i]) chk("stage_data", 32'(stage_data_o[i*W +: W]), 32'(mdat[i]));
      chk("in_ready", 32'(in_ready), 32'(e_in_ready));
      chk("out_valid", 32'(out_valid), 32'(e_out_valid));
      if (e_out_valid) chk("out_data", 32'(out_data), 32'(xf(mdat[ST-1], ST-1)));
      chk("retire_cnt", 32'(retire_cnt), 32'(m_ret));
      chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
      if (out_valid && out_ready) got.push_back(out_data);
      if (first_acc < 0 && in_valid && in_ready) first_acc = cyc;
      if (first_out < 0 && out_valid) first_out = cyc;
    end
  end

  // ---------------- stimulus ----------------------------------------------
  int next_item, last_item;

  task automatic step();
    in_valid = (next_item <= last_item);
    in_data  = W'(next_item);
    @(negedge clk);
    if (in_valid && in_ready) next_item++;
    @(posedge clk); #1;
  endtask

  task automatic chk_got(string nm, int exp[$]);
    chk({nm, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < got.size(); k++)
      chk(nm, 32'(got[k]), 32'(exp[k]));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int           exp_q[$];
    logic [CW-1:0] b0, r0;
    next_item = 1;
    last_item = 0;
    #12;
    chk("rst_stage_valid", 32'(stage_valid_o), 32'h0);
    chk("rst_out_valid",   32'(out_valid),     32'h0);
    chk("rst_in_ready",    32'(in_ready),      32'h1);
    chk("rst_retire",      32'(retire_cnt),    32'h0);
    chk("rst_bubble",      32'(bubble_cnt),    32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: ten items through an empty pipe, full throughput
    got.delete(); first_acc = -1; first_out = -1;
    out_ready = 1'b1; next_item = 1; last_item = 10;
    repeat (20) step();
    exp_q = {1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    chk_got("stream_order", exp_q);
    chk("latency", 32'(first_out - first_acc), 32'(ST));
    chk("retire_10", 32'(retire_cnt), 32'd10);

    // 2: backpressure fills exactly STAGES slots
    got.delete(); out_ready = 1'b0; next_item = 1; last_item = 10;
    repeat (8) step();
    chk("accepts_when_blocked", 32'(next_item - 1), 32'd5);
    chk("in_ready_full", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    repeat (15) step();
    chk_got("backpressure_order", exp_q);

    // 3: one-cycle stall of stage 2 in a full streaming pipe -> one bubble
    out_ready = 1'b0; next_item = 1; last_item = 200;
    repeat (5) step();
    out_ready = 1'b1;
    b0 = bubble_cnt;
    repeat (3) step();
    stall_req = 5'b00100;
    step();
    stall_req = '0;
    repeat (6) step();
    chk("stall_bubble", 32'(CW'(bubble_cnt - b0)), 32'd1);

    // 5: flush of the oldest stage together with a stall empties everything
    stall_req = 5'b00100; flush_req = 5'b10000; in_valid = 1'b1;
    @(negedge clk);
    r0 = retire_cnt;
    chk("flush_all_out_valid", 32'(out_valid), 32'h0);
    chk("flush_all_in_ready",  32'(in_ready),  32'h0);
    @(posedge clk); #1;
    stall_req = '0; flush_req = '0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_all_empty",  32'(stage_valid_o), 32'h0);
    chk("flush_all_retire", 32'(retire_cnt),    32'(r0));
    @(posedge clk); #1;

    // 4: flush of stage 1 kills the two youngest items only
    got.delete(); out_ready = 1'b0; next_item = 'h51; last_item = 'h55;
    repeat (5) step();
    last_item = 'h56; flush_req = 5'b00010; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h56;
    @(negedge clk);
    chk("flush1_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    flush_req = '0;
    repeat (10) step();
    exp_q = {'h51, 'h52, 'h53, 'h56};
    chk_got("flush1_order", exp_q);

    // 6: counter wrap, then asynchronous reset mid-stream
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1; next_item = 1; last_item = 17;
    repeat (25) step();
    chk("retire_wrap", 32'(retire_cnt), 32'd1);
    next_item = 1; last_item = 50;
    repeat (8) step();
    chk("pre_rst_out_valid", 32'(out_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid),     32'h0);
    chk("async_rst_valid",     32'(stage_valid_o), 32'h0);
    chk("async_rst_retire",    32'(retire_cnt),    32'h0);
    chk("async_rst_bubble",    32'(bubble_cnt),    32'h0);
    chk("async_rst_in_ready",  32'(in_ready),      32'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    // randomized traffic against the model, non-identity stage logic
    xf_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < ST; s++) begin
        stall_req[s] = ($urandom_range(0, 9) == 0);
        flush_req[s] = ($urandom_range(0, 49) == 0);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; stall_req = '0; flush_req = '0;
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
